// File: rtl/serial_rx_sequencer_if.sv
// Bundle between the receive sequencer, its SIPO shift register and the byte consumer.
// Parity_Error exists only when RX_PARITY_EN is defined.
interface serial_rx_sequencer_if;
`ifdef RX_PARITY_EN
    logic Parity_Error;
`endif
    logic Serial_Data;
    logic Shift_Flag;
    logic Sipo_Reset;
    logic Byte_Valid;
    logic Byte_Ready;
    logic Frame_Error;
    logic Overrun;
    logic Busy;

    modport master (
`ifdef RX_PARITY_EN
        output Parity_Error,
`endif
        output Serial_Data, Shift_Flag, Sipo_Reset, Byte_Valid,
        output Frame_Error, Overrun, Busy,
        input  Byte_Ready
    );

    modport slave (
`ifdef RX_PARITY_EN
        input  Parity_Error,
`endif
        input  Serial_Data, Shift_Flag, Sipo_Reset, Byte_Valid,
        input  Frame_Error, Overrun, Busy,
        output Byte_Ready
    );
endinterface

// File: rtl/serial_rx_sequencer.sv
// UART-style receive sequencer driving an external 8-bit SIPO; RX_PARITY_EN adds an even-parity bit.
// Latency: Byte_Valid rises 1 cycle after the stop-bit sample (plus SYNC_STAGES on the line input).
// Backpressure: Byte_Valid holds until Byte_Ready; a new start while still valid drops it and pulses Overrun.
module serial_rx_sequencer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                          CLOCK_50,
    input  logic                          Reset_n,
    input  logic                          Serial_In,
    serial_rx_sequencer_if.master         rx_if
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] HALF_LD = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] FULL_LD = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx;

    state_t         state_q, state_d;
    logic [BW-1:0]  baud_q,  baud_d;
    logic [2:0]     bit_q,   bit_d;
    logic           sdat_q,  sdat_d;
    logic           shift_q, shift_d;
    logic           srst_q,  srst_d;
    logic           valid_q, valid_d;
    logic           ferr_q,  ferr_d;
    logic           ovr_q,   ovr_d;
`ifdef RX_PARITY_EN
    logic           par_q,   par_d;
    logic           ppend_q, ppend_d;
    logic           perr_q,  perr_d;
`endif

    // The line idles high, so the synchroniser presets to 1 to avoid a phantom start after reset.
    always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
        if (!Reset_n) sync_q <= '1;
        else          sync_q <= {sync_q[SYNC_STAGES-2:0], Serial_In};
    end

    assign rx = sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sdat_q  <= 1'b0;
            shift_q <= 1'b0;
            srst_q  <= 1'b0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef RX_PARITY_EN
            par_q   <= 1'b0;
            ppend_q <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            sdat_q  <= sdat_d;
            shift_q <= shift_d;
            srst_q  <= srst_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
`ifdef RX_PARITY_EN
            par_q   <= par_d;
            ppend_q <= ppend_d;
            perr_q  <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = (baud_q != '0) ? baud_q - BW'(1) : baud_q;
        bit_d   = bit_q;
        sdat_d  = sdat_q;
        shift_d = 1'b0;
        srst_d  = 1'b0;
        valid_d = valid_q && !rx_if.Byte_Ready;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
`ifdef RX_PARITY_EN
        par_d   = par_q;
        ppend_d = ppend_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!rx) begin
                    srst_d  = 1'b1;
                    baud_d  = HALF_LD;
                    valid_d = 1'b0;
                    ovr_d   = valid_q && !rx_if.Byte_Ready;
                    state_d = START;
                end
            end
            START: begin
                if (baud_q == '0) begin
                    if (rx) begin
                        state_d = IDLE;
                    end else begin
                        baud_d  = FULL_LD;
                        bit_d   = '0;
`ifdef RX_PARITY_EN
                        par_d   = 1'b0;
`endif
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (baud_q == '0) begin
                    sdat_d  = rx;
                    shift_d = 1'b1;
                    bit_d   = bit_q + 3'd1;
                    baud_d  = FULL_LD;
`ifdef RX_PARITY_EN
                    par_d   = par_q ^ rx;
                    if (bit_q == 3'd7) state_d = PARITY;
`else
                    if (bit_q == 3'd7) state_d = STOP;
`endif
                end
            end
`ifdef RX_PARITY_EN
            // The parity bit is checked here but never shifted into the SIPO.
            PARITY: begin
                if (baud_q == '0) begin
                    ppend_d = par_q ^ rx;
                    baud_d  = FULL_LD;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_q == '0) begin
`ifdef RX_PARITY_EN
                    perr_d  = ppend_q;
                    valid_d = rx && !ppend_q;
`else
                    valid_d = rx;
`endif
                    ferr_d  = !rx;
                    state_d = rx ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (rx) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_if.Serial_Data = sdat_q;
    assign rx_if.Shift_Flag  = shift_q;
    assign rx_if.Sipo_Reset  = srst_q;
    assign rx_if.Byte_Valid  = valid_q;
    assign rx_if.Frame_Error = ferr_q;
    assign rx_if.Overrun     = ovr_q;
    assign rx_if.Busy        = (state_q != IDLE);
`ifdef RX_PARITY_EN
    assign rx_if.Parity_Error = perr_q;
`endif

endmodule

// File: tb/tb_serial_rx_sequencer.sv
// Bench for serial_rx_sequencer: directed link scenarios plus random frames scored against a
// frame-level model (expected bits, bytes and error counts) and a model of the external SIPO.
module tb_serial_rx_sequencer;

    localparam int CPB  = 16;
    localparam int SYNC = 2;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic ser_in = 1'b1;
    int   cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_rx_sequencer_if bus();

    serial_rx_sequencer #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
        .CLOCK_50  (clk),
        .Reset_n   (rst_n),
        .Serial_In (ser_in),
        .rx_if     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int   n_shift, n_srst, n_ferr, n_ovr, n_valid, n_perr;
    logic ovr_valid_seen;
    logic valid_prev = 1'b0;
    logic [7:0] sipo = 8'h00;
    logic bits_q[$];
    int   shift_t[$];
    logic [7:0] rx_bytes[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // External SIPO model plus event counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.Sipo_Reset) begin
            n_srst++;
            sipo = 8'hFF;
        end
        if (bus.Shift_Flag) begin
            n_shift++;
            bits_q.push_back(bus.Serial_Data);
            shift_t.push_back(cyc);
            sipo = {bus.Serial_Data, sipo[7:1]};
        end
        if (bus.Frame_Error) n_ferr++;
        if (bus.Overrun) begin
            n_ovr++;
            ovr_valid_seen = bus.Byte_Valid;
        end
`ifdef RX_PARITY_EN
        if (bus.Parity_Error) n_perr++;
`endif
        if (bus.Byte_Valid && !valid_prev) begin
            n_valid++;
            rx_bytes.push_back(sipo);
        end
        valid_prev = bus.Byte_Valid;
    end

    function automatic logic [31:0] outs_now();
        logic [31:0] v;
        v = 32'({bus.Serial_Data, bus.Shift_Flag, bus.Sipo_Reset, bus.Byte_Valid,
                 bus.Frame_Error, bus.Overrun, bus.Busy});
`ifdef RX_PARITY_EN
        v = v | 32'({bus.Parity_Error, 7'b0});
`endif
        return v;
    endfunction

    task automatic clear_model();
        n_shift = 0; n_srst = 0; n_ferr = 0; n_ovr = 0; n_valid = 0; n_perr = 0;
        ovr_valid_seen = 1'b1;
        bits_q.delete();
        shift_t.delete();
        rx_bytes.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        ser_in = b;
        repeat (CPB) @(negedge clk);
    endtask

`ifdef RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    // Line is left at the stop-bit level when the frame ends.
    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef RX_PARITY_EN
        drive_bit((^d) ^ par_flip);
`endif
        drive_bit(stop_b);
    endtask

    task automatic wait_valid(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (bus.Byte_Valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_bits(input string tag, input logic [7:0] d);
        chk({tag, "_nshift"}, 32'(bits_q.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            if (i < bits_q.size()) chk({tag, "_bit"}, 32'(bits_q[i]), 32'(d[i]));
    endtask

    task automatic check_byte(input string tag, input logic [7:0] d);
        bit ok;
        wait_valid(60, ok);
        chk({tag, "_valid_timeout"}, 32'(ok), 32'd1);
        chk({tag, "_nbytes"}, 32'(rx_bytes.size()), 32'd1);
        if (rx_bytes.size() > 0) chk({tag, "_byte"}, 32'(rx_bytes[rx_bytes.size()-1]), 32'(d));
    endtask

    task automatic accept();
        bus.Byte_Ready = 1'b1;
        @(negedge clk);
        bus.Byte_Ready = 1'b0;
        chk("accept_drop", 32'(bus.Byte_Valid), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       stop_b;
        int         hold;
        bit         got;

        bus.Byte_Ready = 1'b0;
        clear_model();

        // Reset state
        idle(3);
        chk("reset_outs", outs_now(), 32'd0);
        rst_n = 1'b1;
        idle(5);
        chk("idle_outs", outs_now(), 32'd0);

        // 1: 0x55, bit spacing, valid held without ready
        clear_model();
        send_frame(8'h55, 1'b1);
        check_byte("s1", 8'h55);
        chk("s1_srst", 32'(n_srst), 32'd1);
        check_bits("s1", 8'h55);
        for (int i = 1; i < shift_t.size(); i++)
            chk("s1_spacing", 32'(shift_t[i] - shift_t[i-1]), 32'(CPB));
        idle(20);
        chk("s1_valid_held", 32'(bus.Byte_Valid), 32'd1);
        accept();
        idle(2);
        chk("s1_valid_stays_low", 32'(bus.Byte_Valid), 32'd0);

        // 2: short glitch is a false start
        clear_model();
        ser_in = 1'b0;
        idle(4);
        ser_in = 1'b1;
        idle(30);
        chk("s2_nshift", 32'(n_shift), 32'd0);
        chk("s2_nvalid", 32'(n_valid), 32'd0);
        chk("s2_busy", 32'(bus.Busy), 32'd0);

        // 3: framing error, break held, then recovery
        clear_model();
        idle(5);
        send_frame(8'hA3, 1'b0);
        idle(40);
        check_bits("s3", 8'hA3);
        chk("s3_ferr", 32'(n_ferr), 32'd1);
        chk("s3_valid", 32'(n_valid), 32'd0);
        chk("s3_busy_break", 32'(bus.Busy), 32'd1);
        chk("s3_srst_no_retrigger", 32'(n_srst), 32'd1);
        ser_in = 1'b1;
        idle(6);
        chk("s3_busy_after", 32'(bus.Busy), 32'd0);
        clear_model();
        send_frame(8'h3C, 1'b1);
        check_byte("s3b", 8'h3C);
        accept();

        // 4: back-to-back frames without ready
        clear_model();
        idle(5);
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        wait_valid(60, got);
        chk("s4_valid_timeout", 32'(got), 32'd1);
        chk("s4_ovr", 32'(n_ovr), 32'd1);
        chk("s4_valid_cleared_at_ovr", 32'(ovr_valid_seen), 32'd0);
        chk("s4_nbytes", 32'(rx_bytes.size()), 32'd2);
        if (rx_bytes.size() == 2) begin
            chk("s4_byte0", 32'(rx_bytes[0]), 32'h12);
            chk("s4_byte1", 32'(rx_bytes[1]), 32'h34);
        end
        accept();

        // 5: reset at the 4th shift
        clear_model();
        idle(5);
        fork
            send_frame(8'h5A, 1'b1);
            begin
                got = 1'b0;
                for (int i = 0; i < 400; i++) begin
                    @(negedge clk);
                    if (n_shift >= 4) begin
                        got = 1'b1;
                        break;
                    end
                end
                chk("s5_reach_4th_shift", 32'(got), 32'd1);
                rst_n = 1'b0;
                #1;
                chk("s5_reset_outs", outs_now(), 32'd0);
            end
        join
        ser_in = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(5);
        clear_model();
        send_frame(8'hF0, 1'b1);
        check_byte("s5", 8'hF0);
        check_bits("s5", 8'hF0);
        accept();

`ifdef RX_PARITY_EN
        // 6: good then bad parity
        clear_model();
        par_flip = 1'b0;
        send_frame(8'h07, 1'b1);
        check_byte("s6_good", 8'h07);
        accept();
        clear_model();
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        idle(10);
        par_flip = 1'b0;
        chk("s6_perr", 32'(n_perr), 32'd1);
        chk("s6_no_valid", 32'(n_valid), 32'd0);
`endif

        // Random frames
        for (int k = 0; k < 16; k++) begin
            d      = 8'($urandom);
            stop_b = ($urandom_range(0, 3) != 0);
            clear_model();
            idle($urandom_range(1, 20));
            send_frame(d, stop_b);
            if (stop_b) begin
                check_byte("rnd", d);
                hold = $urandom_range(0, 10);
                idle(hold);
                chk("rnd_valid_held", 32'(bus.Byte_Valid), 32'd1);
                accept();
            end else begin
                idle(10);
                chk("rnd_ferr", 32'(n_ferr), 32'd1);
                chk("rnd_no_valid", 32'(n_valid), 32'd0);
                ser_in = 1'b1;
                idle(5);
                chk("rnd_busy_after", 32'(bus.Busy), 32'd0);
            end
            check_bits("rnd", d);
            chk("rnd_srst", 32'(n_srst), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
